// File: rtl/adder_module_pkg.sv
// adder_module_pkg: shared width constants for the carry-lookahead adder
package adder_module_pkg;
  localparam int ADDER_WIDTH = 32;
  localparam int CLA_GROUP   = 4;
endpackage

// File: rtl/adder_module_cla_4bit.sv
// cla_4bit: 4-bit lookahead group producing sum bits and group generate/propagate
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       g,
  output logic       p
);
  logic [3:0] gi, pi, c;
  assign gi = a & b;
  assign pi = a ^ b;
  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & cin);
  assign s = pi ^ c;
  // group terms exclude cin so the second-level lookahead sees no loop
  assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p = &pi;
endmodule

// File: rtl/adder_module.sv
// adder_module: registered 32-bit two-level carry-lookahead adder with carry-out
module adder_module
  import adder_module_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDER_WIDTH-1:0] A,
  input  logic [ADDER_WIDTH-1:0] B,
  output logic [ADDER_WIDTH-1:0] Sum,
  output logic                   Carry_Out
);
  localparam int NG = ADDER_WIDTH / CLA_GROUP;
  logic [NG-1:0]          gg, pg;
  logic [NG:0]            c;
  logic [ADDER_WIDTH-1:0] s;
  // carry into group i, flattened as OR of g[j] & p[j+1..i-1]
  function automatic logic group_carry(input int i, input logic [NG-1:0] g_v, input logic [NG-1:0] p_v);
    logic r, t;
    r = 1'b0;
    for (int j = 0; j < i; j++) begin
      t = g_v[j];
      for (int k = j + 1; k < i; k++) t = t & p_v[k];
      r = r | t;
    end
    return r;
  endfunction
  for (genvar i = 0; i < NG; i++) begin : g_cla
    cla_4bit u_cla (
      .a  (A[i*CLA_GROUP +: CLA_GROUP]),
      .b  (B[i*CLA_GROUP +: CLA_GROUP]),
      .cin(c[i]),
      .s  (s[i*CLA_GROUP +: CLA_GROUP]),
      .g  (gg[i]),
      .p  (pg[i])
    );
  end
  always_comb begin
    c[0] = 1'b0;
    for (int i = 1; i <= NG; i++) c[i] = group_carry(i, gg, pg);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {Carry_Out, Sum} <= '0;
    else        {Carry_Out, Sum} <= {c[NG], s};
endmodule

// File: tb/tb_adder_module.sv
// tb_adder_module: directed and random checks of the registered adder against a 33-bit reference
module tb_adder_module;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic [31:0] Sum;
  logic        Carry_Out;
  int          compared = 0;
  int          mismatched = 0;
  logic [32:0] exp_prev;
  string       tag_prev;

  adder_module dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .Sum      (Sum),
    .Carry_Out(Carry_Out)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got {co,sum}=%h expected %h", tag, got, exp);
    end
  endtask

  // each negedge: verify result of previous pair, then present the next pair
  task automatic step(input logic [31:0] a, input logic [31:0] b, input string tag);
    @(negedge clk);
    check(tag_prev, {Carry_Out, Sum}, exp_prev);
    A = a;
    B = b;
    exp_prev = ref_sum(a, b);
    tag_prev = tag;
  endtask

  initial begin
    rst_n = 1'b0;
    A = 32'd12;
    B = 32'd3;
    #1 check("rst_immediate", {Carry_Out, Sum}, 33'd0);
    repeat (3) begin
      @(posedge clk);
      #1 check("rst_hold", {Carry_Out, Sum}, 33'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_release_pre_edge", {Carry_Out, Sum}, 33'd0);
    @(posedge clk);
    #1 check("rst_release_load", {Carry_Out, Sum}, 33'd15);
    exp_prev = 33'd15;
    tag_prev = "rst_release_hold";
    step(32'd6969, 32'd28, "d6969_28");
    step(32'd119, 32'd29, "d119_29");
    step(32'd56, 32'd52, "d56_52");
    step(32'd559, 32'd31, "d559_31");
    @(negedge clk);
    check(tag_prev, {Carry_Out, Sum}, 33'd590);
    #2 rst_n = 1'b0;
    #1 check("async_rst_drop", {Carry_Out, Sum}, 33'd0);
    @(posedge clk);
    #1 check("async_rst_hold", {Carry_Out, Sum}, 33'd0);
    @(negedge clk);
    check("async_rst_hold2", {Carry_Out, Sum}, 33'd0);
    rst_n = 1'b1;
    exp_prev = 33'd590;
    tag_prev = "async_rst_reload";
    step(32'hFFFF_FFFF, 32'd1, "wrap_one");
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, "wrap_all_ones");
    step(32'h0FFF_FFFF, 32'h0000_0001, "prop_groups");
    step(32'h8000_0000, 32'h8000_0000, "msb_carry");
    step(32'd0, 32'd0, "zero");
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ~ra : $urandom;
      step(ra, rb, "random");
    end
    @(negedge clk);
    check(tag_prev, {Carry_Out, Sum}, exp_prev);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
